tdm_rx_axis_4ch: RTL and testbench

// - Receives the 4-slot TDM microphone stream (BCLK/FSYNC/SDATA) and emits one 32-bit
//   AXI4-Stream word per slot, strictly ordered ch0,ch1,ch2,ch3 per frame.
// - Sits directly upstream of axis_bram_4_channel and drives its s00 slave port.
// - That consumer's channel rotation is free-running, so partial frames are never emitted.

---
 rtl/tdm_rx_axis_4ch_pkg.sv | 19 +
 rtl/tdm_rx_axis_4ch_fifo.sv | 74 +++++++
 rtl/tdm_rx_axis_4ch.sv | 245 ++++++++++++++++++++++++
 tb/tb_tdm_rx_axis_4ch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_rx_axis_4ch_pkg.sv
// Shared types and helpers for the 4-slot TDM microphone receiver.
package tdm_rx_axis_4ch_pkg;

  // Width of one AXI4-Stream data beat; one TDM slot maps onto one beat.
  localparam int AXIS_TDATA_W = 32;

  // Receiver framing states.
  typedef enum logic [1:0] {
    TDM_HUNT = 2'd0,
    TDM_SKIP = 2'd1,
    TDM_RUN  = 2'd2
  } tdm_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_rx_axis_4ch_fifo.sv
// Synchronous output FIFO with frame commit and write-pointer rollback.
// Words become visible to the reader only once committed, so a frame that is
// abandoned part-way can be rewound without the consumer ever seeing it.
module tdm_rx_axis_4ch_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     wr_commit_i,
  input  logic                     wr_rewind_i,
  input  logic [$clog2(DEPTH):0]   rewind_ptr_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   free_o,
  output logic [$clog2(DEPTH):0]   wr_ptr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] commitPtr_q, commitPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;

  // Pointer update: rewind beats write, commit publishes everything written so far.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    commitPtr_d = commitPtr_q;
    rdPtr_d     = rdPtr_q;
    if (wr_rewind_i) begin
      wrPtr_d = rewind_ptr_i;
    end else if (wr_en_i) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (wr_commit_i && !wr_rewind_i) begin
      commitPtr_d = wrPtr_d;
    end
    if (rd_en_i && rd_valid_o) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q     <= '0;
      commitPtr_q <= '0;
      rdPtr_q     <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      commitPtr_q <= commitPtr_d;
      rdPtr_q     <= rdPtr_d;
    end
  end

  // Storage array; contents need no reset because validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_rewind_i) begin
      mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_valid_o = (commitPtr_q != rdPtr_q);
  assign rd_data_o  = mem_q[rdPtr_q[AW-1:0]];
  assign free_o     = PTR_DEPTH - (wrPtr_q - rdPtr_q);
  assign wr_ptr_o   = wrPtr_q;

endmodule

// File: rtl/tdm_rx_axis_4ch.sv
// TDM (BCLK/FSYNC/SDATA) receiver producing one AXI4-Stream word per slot.
// Frames are admitted or dropped whole so the downstream channel rotation
// never slips; a misplaced FSYNC discards the frame in progress.
module tdm_rx_axis_4ch
  import tdm_rx_axis_4ch_pkg::*;
#(
  parameter int N_SLOTS        = 4,
  parameter int SLOT_W         = AXIS_TDATA_W,
  parameter int DATA_DELAY     = 1,
  parameter int FRAMES_PER_PKT = 4096,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_areset,
  input  logic                  tdm_bclk,
  input  logic                  tdm_fsync,
  input  logic                  tdm_sdata,
  input  logic                  m00_axis_tready,
  output logic [SLOT_W-1:0]     m00_axis_tdata,
  output logic [SLOT_W/8-1:0]   m00_axis_tstrb,
  output logic                  m00_axis_tlast,
  output logic                  m00_axis_tvalid,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  err_clr
);

  localparam int BW = cnt_w(SLOT_W);
  localparam int SW = cnt_w(N_SLOTS);
  localparam int FW = cnt_w(FRAMES_PER_PKT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST   = BW'(SLOT_W - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(N_SLOTS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PKT - 1);
  localparam logic [AW:0]   NEED_FREE  = (AW+1)'(N_SLOTS);

  // Synchronizer stages, packed as {bclk, fsync, sdata}.
  logic [2:0] sync1_q, sync2_q;
  logic       bclkPrev_q;
  logic       fsyncEvt_q;
  logic       bclkS, fsyncS, sdataS;
  logic       bclkEvt, fsyncRise;

  tdm_state_e        state_q, state_d;
  logic [BW-1:0]     bitCnt_q, bitCnt_d;
  logic [SW-1:0]     slotCnt_q, slotCnt_d;
  logic [FW-1:0]     frameCnt_q, frameCnt_d;
  logic [SLOT_W-1:0] shreg_q, shreg_d;
  logic              admitted_q, admitted_d;
  logic [AW:0]       frameStart_q, frameStart_d;
  logic              push_q, push_d;
  logic              pushLast_q, pushLast_d;
  logic              commit_q, commit_d;
  logic              rewind_q, rewind_d;
  logic              overflow_q, frameErr_q;

  logic              process;
  logic [BW-1:0]     curBit;
  logic [SW-1:0]     curSlot;
  logic              admitNow;
  logic              onTime;
  logic              ovfSet, errSet;

  logic [SLOT_W:0]   fifoRdData;
  logic              fifoValid;
  logic [AW:0]       fifoFree;
  logic [AW:0]       fifoWrPtr;

  // Two-flop synchronizers plus a history flop to find BCLK rising edges.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      bclkPrev_q <= 1'b0;
      fsyncEvt_q <= 1'b0;
    end else begin
      sync1_q    <= {tdm_bclk, tdm_fsync, tdm_sdata};
      sync2_q    <= sync1_q;
      bclkPrev_q <= sync2_q[2];
      if (bclkEvt) begin
        fsyncEvt_q <= sync2_q[1];
      end
    end
  end

  assign bclkS     = sync2_q[2];
  assign fsyncS    = sync2_q[1];
  assign sdataS    = sync2_q[0];
  assign bclkEvt   = bclkS && !bclkPrev_q;
  assign fsyncRise = bclkEvt && fsyncS && !fsyncEvt_q;

  // An FSYNC edge is on time when it lands where the free-running counters
  // already expect a frame boundary: on the slot-0 MSB with no delay, or on
  // the final LSB of the frame when the MSB follows one bit later.
  assign onTime = (DATA_DELAY == 0) ? (bitCnt_q == '0 && slotCnt_q == '0)
                                    : (bitCnt_q == BIT_LAST && slotCnt_q == SLOT_LAST);

  // Next-state logic: framing FSM, bit/slot/frame counters, admission and push tagging.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    slotCnt_d    = slotCnt_q;
    frameCnt_d   = frameCnt_q;
    shreg_d      = shreg_q;
    admitted_d   = admitted_q;
    frameStart_d = frameStart_q;
    push_d       = 1'b0;
    pushLast_d   = 1'b0;
    commit_d     = 1'b0;
    rewind_d     = 1'b0;
    ovfSet       = 1'b0;
    errSet       = 1'b0;
    process      = 1'b0;
    curBit       = bitCnt_q;
    curSlot      = slotCnt_q;
    admitNow     = admitted_q;

    if (bclkEvt) begin
      unique case (state_q)
        TDM_HUNT: begin
          if (fsyncRise) begin
            curBit  = '0;
            curSlot = '0;
            if (DATA_DELAY == 0) begin
              state_d = TDM_RUN;
              process = 1'b1;
            end else begin
              state_d = TDM_SKIP;
            end
          end
        end
        TDM_SKIP: begin
          state_d = TDM_RUN;
          process = 1'b1;
        end
        TDM_RUN: begin
          if (fsyncRise && !onTime) begin
            errSet     = 1'b1;
            rewind_d   = admitted_q;
            admitted_d = 1'b0;
            curBit     = '0;
            curSlot    = '0;
            bitCnt_d   = '0;
            slotCnt_d  = '0;
            if (DATA_DELAY == 0) begin
              process = 1'b1;
            end else begin
              state_d = TDM_SKIP;
            end
          end else begin
            process = 1'b1;
          end
        end
        default: state_d = TDM_HUNT;
      endcase
    end

    if (process) begin
      shreg_d = {shreg_q[SLOT_W-2:0], sdataS};
      if (curBit == '0 && curSlot == '0) begin
        admitNow   = (fifoFree >= NEED_FREE);
        admitted_d = admitNow;
        ovfSet     = !admitNow;
        if (admitNow) begin
          frameStart_d = fifoWrPtr;
        end
      end
      if (curBit == BIT_LAST) begin
        bitCnt_d   = '0;
        push_d     = admitNow;
        pushLast_d = (curSlot == SLOT_LAST) && (frameCnt_q == FRAME_LAST);
        if (curSlot == SLOT_LAST) begin
          slotCnt_d = '0;
          commit_d  = admitNow;
          if (admitNow) begin
            frameCnt_d = (frameCnt_q == FRAME_LAST) ? '0 : frameCnt_q + FW'(1);
          end
        end else begin
          slotCnt_d = curSlot + SW'(1);
        end
      end else begin
        bitCnt_d = curBit + BW'(1);
      end
    end
  end

  // State, datapath and sticky error registers; a new error beats err_clr.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q      <= TDM_HUNT;
      bitCnt_q     <= '0;
      slotCnt_q    <= '0;
      frameCnt_q   <= '0;
      shreg_q      <= '0;
      admitted_q   <= 1'b0;
      frameStart_q <= '0;
      push_q       <= 1'b0;
      pushLast_q   <= 1'b0;
      commit_q     <= 1'b0;
      rewind_q     <= 1'b0;
      overflow_q   <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      slotCnt_q    <= slotCnt_d;
      frameCnt_q   <= frameCnt_d;
      shreg_q      <= shreg_d;
      admitted_q   <= admitted_d;
      frameStart_q <= frameStart_d;
      push_q       <= push_d;
      pushLast_q   <= pushLast_d;
      commit_q     <= commit_d;
      rewind_q     <= rewind_d;
      overflow_q   <= ovfSet | (overflow_q & ~err_clr);
      frameErr_q   <= errSet | (frameErr_q & ~err_clr);
    end
  end

  tdm_rx_axis_4ch_fifo #(
    .WIDTH (SLOT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (m00_axis_aclk),
    .rst_i        (m00_axis_areset),
    .wr_en_i      (push_q),
    .wr_data_i    ({pushLast_q, shreg_q}),
    .wr_commit_i  (commit_q),
    .wr_rewind_i  (rewind_q),
    .rewind_ptr_i (frameStart_q),
    .rd_en_i      (m00_axis_tready),
    .rd_data_o    (fifoRdData),
    .rd_valid_o   (fifoValid),
    .free_o       (fifoFree),
    .wr_ptr_o     (fifoWrPtr)
  );

  assign m00_axis_tvalid = fifoValid;
  assign m00_axis_tdata  = fifoValid ? fifoRdData[SLOT_W-1:0] : '0;
  assign m00_axis_tlast  = fifoValid & fifoRdData[SLOT_W];
  assign m00_axis_tstrb  = '1;
  assign overflow        = overflow_q;
  assign frame_err       = frameErr_q;

endmodule

// File: tb/tb_tdm_rx_axis_4ch.sv
// Directed bench for tdm_rx_axis_4ch: a DATA_DELAY=1 instance with short
// packets and a DATA_DELAY=0 instance fed the same bits with FSYNC one bit later.
module tb_tdm_rx_axis_4ch;

  logic        aclk = 1'b0;
  logic        rst;
  logic        bclk, fsync, fsync0, sdata, tready, errClr;
  logic        fsPrev;
  logic [31:0] tdata, d0Tdata;
  logic [3:0]  tstrb, d0Tstrb;
  logic        tlast, tvalid, ovf, ferr;
  logic        d0Tlast, d0Tvalid, d0Ovf, d0Ferr;
  logic        d0Tready;

  int total = 0;
  int bad   = 0;

  logic [31:0] capData [$];
  logic        capLast [$];
  logic [3:0]  capStrb [$];
  logic [31:0] d0Data  [$];

  // System clock, 10 ns period.
  always #5 aclk = ~aclk;

  tdm_rx_axis_4ch #(
    .N_SLOTS(4), .SLOT_W(32), .DATA_DELAY(1), .FRAMES_PER_PKT(4), .FIFO_DEPTH(16)
  ) dut (
    .m00_axis_aclk(aclk), .m00_axis_areset(rst),
    .tdm_bclk(bclk), .tdm_fsync(fsync), .tdm_sdata(sdata),
    .m00_axis_tready(tready), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .m00_axis_tvalid(tvalid),
    .overflow(ovf), .frame_err(ferr), .err_clr(errClr)
  );

  tdm_rx_axis_4ch #(
    .N_SLOTS(4), .SLOT_W(32), .DATA_DELAY(0), .FRAMES_PER_PKT(4096), .FIFO_DEPTH(16)
  ) dutD0 (
    .m00_axis_aclk(aclk), .m00_axis_areset(rst),
    .tdm_bclk(bclk), .tdm_fsync(fsync0), .tdm_sdata(sdata),
    .m00_axis_tready(d0Tready), .m00_axis_tdata(d0Tdata), .m00_axis_tstrb(d0Tstrb),
    .m00_axis_tlast(d0Tlast), .m00_axis_tvalid(d0Tvalid),
    .overflow(d0Ovf), .frame_err(d0Ferr), .err_clr(errClr)
  );

  assign d0Tready = 1'b1;

  // Record every accepted beat of both instances on the falling edge.
  always @(negedge aclk) begin
    if (!rst) begin
      if (tvalid && tready) begin
        capData.push_back(tdata);
        capLast.push_back(tlast);
        capStrb.push_back(tstrb);
      end
      if (d0Tvalid) begin
        d0Data.push_back(d0Tdata);
      end
    end
  end

  function automatic logic [31:0] pat(input int f, input int ch);
    return 32'hA000_0000 + 32'(f * 256) + 32'(ch);
  endfunction

  function automatic logic [127:0] mk_frame(input int f);
    return {pat(f, 0), pat(f, 1), pat(f, 2), pat(f, 3)};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_caps();
    capData.delete();
    capLast.delete();
    capStrb.delete();
    d0Data.delete();
  endtask

  // One BCLK period; the delayed copy of FSYNC feeds the zero-delay instance.
  task automatic send_bit(input logic fs, input logic d);
    bclk   = 1'b0;
    fsync0 = fsPrev;
    fsync  = fs;
    fsPrev = fs;
    sdata  = d;
    #30;
    bclk = 1'b1;
    #30;
  endtask

  task automatic send_frame(input logic [127:0] bits, input int nbits, input logic syncLast);
    for (int i = 0; i < nbits; i++) begin
      send_bit(syncLast && (i == nbits - 1), bits[127 - i]);
    end
  endtask

  task automatic send_lead();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bclk   = 1'b0;
    fsync  = 1'b0;
    fsync0 = 1'b0;
    fsPrev = 1'b0;
    sdata  = 1'b0;
    errClr = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    clear_caps();
    wait_cycles(2);
  endtask

  task automatic test_reset();
    tready = 1'b0;
    rst    = 1'b1;
    bclk   = 1'b0;
    fsync  = 1'b0;
    fsync0 = 1'b0;
    fsPrev = 1'b0;
    sdata  = 1'b0;
    errClr = 1'b0;
    wait_cycles(4);
    total++; if (tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%b want=0", tvalid); end
    total++; if (tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast got=%b want=0", tlast); end
    total++; if (tdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_tdata got=%h want=0", tdata); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", ovf); end
    total++; if (ferr !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err got=%b want=0", ferr); end
    total++; if (tstrb !== 4'hF) begin bad++; $display("[TB] FAIL reset_tstrb got=%h want=F", tstrb); end
    rst = 1'b0;
    clear_caps();
    wait_cycles(3);
    total++; if (tvalid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_tvalid got=%b want=0", tvalid); end
  endtask

  task automatic test_nominal();
    do_reset();
    tready = 1'b1;
    send_lead();
    for (int f = 0; f < 3; f++) send_frame(mk_frame(0), 128, 1'b1);
    wait_cycles(20);
    total++; if (capData.size() !== 12) begin bad++; $display("[TB] FAIL nominal_count got=%0d want=12", capData.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(0, i % 4)) begin bad++; $display("[TB] FAIL nominal_data[%0d] got=%h want=%h", i, capData[i], pat(0, i % 4)); end
        total++; if (capLast[i] !== 1'b0) begin bad++; $display("[TB] FAIL nominal_tlast[%0d] got=%b want=0", i, capLast[i]); end
        total++; if (capStrb[i] !== 4'hF) begin bad++; $display("[TB] FAIL nominal_tstrb[%0d] got=%h want=F", i, capStrb[i]); end
      end
    end
  endtask

  task automatic test_delay0();
    total++; if (d0Data.size() !== 12) begin bad++; $display("[TB] FAIL delay0_count got=%0d want=12", d0Data.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < d0Data.size()) begin
        total++; if (d0Data[i] !== pat(0, i % 4)) begin bad++; $display("[TB] FAIL delay0_data[%0d] got=%h want=%h", i, d0Data[i], pat(0, i % 4)); end
      end
    end
  endtask

  task automatic test_packet();
    do_reset();
    tready = 1'b1;
    send_lead();
    for (int f = 0; f < 8; f++) send_frame(mk_frame(f), 128, 1'b1);
    wait_cycles(20);
    total++; if (capData.size() !== 32) begin bad++; $display("[TB] FAIL packet_count got=%0d want=32", capData.size()); end
    for (int i = 0; i < 32; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(i / 4, i % 4)) begin bad++; $display("[TB] FAIL packet_data[%0d] got=%h want=%h", i, capData[i], pat(i / 4, i % 4)); end
        total++; if (capLast[i] !== ((i == 15) || (i == 31))) begin bad++; $display("[TB] FAIL packet_tlast[%0d] got=%b want=%b", i, capLast[i], (i == 15) || (i == 31)); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tready = 1'b0;
    send_lead();
    for (int f = 0; f < 5; f++) send_frame(mk_frame(f), 128, 1'b1);
    wait_cycles(20);
    total++; if (capData.size() !== 0) begin bad++; $display("[TB] FAIL bp_no_beats got=%0d want=0", capData.size()); end
    total++; if (tvalid !== 1'b1) begin bad++; $display("[TB] FAIL bp_tvalid got=%b want=1", tvalid); end
    total++; if (tdata !== pat(0, 0)) begin bad++; $display("[TB] FAIL bp_head_held got=%h want=%h", tdata, pat(0, 0)); end
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL bp_overflow got=%b want=1", ovf); end
    total++; if (ferr !== 1'b0) begin bad++; $display("[TB] FAIL bp_frame_err got=%b want=0", ferr); end
    tready = 1'b1;
    wait_cycles(40);
    total++; if (capData.size() !== 16) begin bad++; $display("[TB] FAIL bp_drain_count got=%0d want=16", capData.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(i / 4, i % 4)) begin bad++; $display("[TB] FAIL bp_drain_data[%0d] got=%h want=%h", i, capData[i], pat(i / 4, i % 4)); end
        total++; if (capLast[i] !== (i == 15)) begin bad++; $display("[TB] FAIL bp_drain_tlast[%0d] got=%b want=%b", i, capLast[i], i == 15); end
      end
    end
    clear_caps();
    send_frame(mk_frame(5), 128, 1'b1);
    wait_cycles(20);
    total++; if (capData.size() !== 4) begin bad++; $display("[TB] FAIL bp_next_count got=%0d want=4", capData.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(5, i)) begin bad++; $display("[TB] FAIL bp_next_data[%0d] got=%h want=%h", i, capData[i], pat(5, i)); end
        total++; if (capLast[i] !== 1'b0) begin bad++; $display("[TB] FAIL bp_next_tlast[%0d] got=%b want=0", i, capLast[i]); end
      end
    end
  endtask

  task automatic test_early_fsync();
    clear_caps();
    send_frame(mk_frame(6), 41, 1'b1);
    send_frame(mk_frame(7), 128, 1'b1);
    wait_cycles(20);
    total++; if (ferr !== 1'b1) begin bad++; $display("[TB] FAIL early_frame_err got=%b want=1", ferr); end
    total++; if (capData.size() !== 4) begin bad++; $display("[TB] FAIL early_count got=%0d want=4", capData.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(7, i)) begin bad++; $display("[TB] FAIL early_data[%0d] got=%h want=%h", i, capData[i], pat(7, i)); end
        total++; if (capLast[i] !== 1'b0) begin bad++; $display("[TB] FAIL early_tlast[%0d] got=%b want=0", i, capLast[i]); end
      end
    end
  endtask

  task automatic test_err_clr();
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL errclr_pre_overflow got=%b want=1", ovf); end
    errClr = 1'b1;
    wait_cycles(1);
    errClr = 1'b0;
    wait_cycles(1);
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL errclr_overflow got=%b want=0", ovf); end
    total++; if (ferr !== 1'b0) begin bad++; $display("[TB] FAIL errclr_frame_err got=%b want=0", ferr); end
  endtask

  task automatic test_reset_mid_frame();
    tready = 1'b0;
    clear_caps();
    send_frame(mk_frame(8), 128, 1'b1);
    wait_cycles(20);
    total++; if (tvalid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_tvalid got=%b want=1", tvalid); end
    send_frame(mk_frame(9), 80, 1'b0);
    #2;
    rst = 1'b1;
    #2;
    total++; if (tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tvalid got=%b want=0", tvalid); end
    total++; if (tdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_tdata got=%h want=0", tdata); end
    total++; if (tlast !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tlast got=%b want=0", tlast); end
    wait_cycles(3);
    rst = 1'b0;
    clear_caps();
    tready = 1'b1;
    wait_cycles(2);
    send_frame(mk_frame(9), 48, 1'b1);
    send_frame(mk_frame(10), 128, 1'b1);
    wait_cycles(20);
    total++; if (capData.size() !== 4) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=4", capData.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < capData.size()) begin
        total++; if (capData[i] !== pat(10, i)) begin bad++; $display("[TB] FAIL midrst_data[%0d] got=%h want=%h", i, capData[i], pat(10, i)); end
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_nominal();
    test_delay0();
    test_packet();
    test_backpressure();
    test_early_fsync();
    test_err_clr();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
